// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with register-file writeback and exception status reporting.
module multdiv_unit #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned STATUS_REG   = 30,
    parameter int unsigned CODE_MULOVF  = 1,
    parameter int unsigned CODE_DIVZERO = 2,
    parameter int unsigned CODE_DIVOVF  = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [4:0]       ctrl_destReg,
    output logic             busy,
    output logic             data_resultRDY,
    output logic             data_exception,
    output logic [WIDTH-1:0] data_result,
    output logic             wb_writeEnable,
    output logic [4:0]       wb_writeReg,
    output logic [WIDTH-1:0] wb_data
);
    localparam int unsigned   CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e             r_state, w_state_next;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_a, r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_sign, r_is_div, r_divzero;
    logic [4:0]         r_tag;
    logic               r_rdy, r_exc;
    logic [WIDTH-1:0]   r_result, r_wb_data;
    logic [4:0]         r_wb_reg;

    logic               w_start, w_start_div;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [WIDTH:0]     w_mul_sum, w_rem_sh;
    logic [WIDTH-1:0]   w_rem_diff, w_rem_next, w_quot;
    logic               w_qbit, w_mul_ovf;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_res, w_code;
    logic               w_exc;

    assign w_start     = ctrl_MULT || ctrl_DIV;
    assign w_start_div = !ctrl_MULT && ctrl_DIV;
    assign w_mag_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign w_mag_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // Multiply: add into the high half, then shift the whole accumulator right.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_b[0] ? r_a : '0)};

    // Divide: remainder in the high half, quotient bits shift into the low half.
    assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_a[WIDTH-1]};
    assign w_qbit     = w_rem_sh >= {1'b0, r_b};
    assign w_rem_diff = w_rem_sh[WIDTH-1:0] - r_b;
    assign w_rem_next = w_qbit ? w_rem_diff : w_rem_sh[WIDTH-1:0];

    assign w_prod    = r_sign ? -r_acc : r_acc;
    assign w_mul_ovf = !((&w_prod[2*WIDTH-1:WIDTH-1]) || !(|w_prod[2*WIDTH-1:WIDTH-1]));
    assign w_quot    = r_acc[WIDTH-1:0];

    always_comb begin
        w_res  = '0;
        w_exc  = 1'b0;
        w_code = '0;
        if (r_is_div) begin
            if (r_divzero) begin
                w_exc  = 1'b1;
                w_code = WIDTH'(CODE_DIVZERO);
            end else if (w_quot[WIDTH-1] && !r_sign) begin
                // Only -2^(W-1) / -1 yields an unsigned quotient this large with positive sign.
                w_res  = w_quot;
                w_exc  = 1'b1;
                w_code = WIDTH'(CODE_DIVOVF);
            end else begin
                w_res = r_sign ? -w_quot : w_quot;
            end
        end else begin
            w_res  = w_prod[WIDTH-1:0];
            w_exc  = w_mul_ovf;
            w_code = WIDTH'(CODE_MULOVF);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (ctrl_MULT) begin
                    w_state_next = StMul;
                end else if (ctrl_DIV) begin
                    w_state_next = (data_operandB == '0) ? StDone : StDiv;
                end
            end
            StMul, StDiv: begin
                if (r_cnt == CNT_LAST) w_state_next = StDone;
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_sign    <= 1'b0;
            r_is_div  <= 1'b0;
            r_divzero <= 1'b0;
            r_tag     <= '0;
            r_rdy     <= 1'b0;
            r_exc     <= 1'b0;
            r_result  <= '0;
            r_wb_reg  <= '0;
            r_wb_data <= '0;
        end else begin
            r_rdy <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_a       <= w_mag_a;
                        r_b       <= w_mag_b;
                        r_sign    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        r_tag     <= ctrl_destReg;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        r_is_div  <= w_start_div;
                        r_divzero <= w_start_div && (data_operandB == '0);
                    end
                end
                StMul: begin
                    r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + CW'(1);
                end
                StDiv: begin
                    r_acc <= {w_rem_next, r_acc[WIDTH-2:0], w_qbit};
                    r_a   <= r_a << 1;
                    r_cnt <= r_cnt + CW'(1);
                end
                StDone: begin
                    r_rdy     <= 1'b1;
                    r_exc     <= w_exc;
                    r_result  <= w_res;
                    r_wb_reg  <= w_exc ? 5'(STATUS_REG) : r_tag;
                    r_wb_data <= w_exc ? w_code : w_res;
                end
                default: ;
            endcase
        end
    end

    assign busy           = (r_state != StIdle);
    assign data_resultRDY = r_rdy;
    assign data_exception = r_exc;
    assign data_result    = r_result;
    assign wb_writeEnable = r_rdy;
    assign wb_writeReg    = r_wb_reg;
    assign wb_data        = r_wb_data;

endmodule
